// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies debounced button gestures into short/long/double-click pulses
module btn_event_decoder #(
  parameter int TICK_DIV     = 10,
  parameter int LONG_TICKS   = 50,
  parameter int DCLICK_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             db_in,
  input  logic             clr,
  output logic             short_press,
  output logic             long_press,
  output logic             double_click,
  output logic [CNT_W-1:0] event_cnt,
  output logic             busy
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(LONG_TICKS > DCLICK_TICKS ? LONG_TICKS : DCLICK_TICKS);
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT2, PRESSED2} state_t;
  state_t        state, nxt;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic          db_d, tick, rise, fall, sp, lp, dc;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  assign rise = db_in & ~db_d;
  assign fall = ~db_in & db_d;
  // Edges take priority over the tick-based timeouts in the same cycle
  always_comb begin
    nxt = state;
    sp  = 1'b0;
    lp  = 1'b0;
    dc  = 1'b0;
    case (state)
      IDLE:      nxt = rise ? PRESSED : IDLE;
      PRESSED: begin
        lp  = ~fall & tick & (tcnt == TW'(LONG_TICKS - 1));
        nxt = fall ? WAIT2 : lp ? LONG_HELD : PRESSED;
      end
      LONG_HELD: nxt = fall ? IDLE : LONG_HELD;
      WAIT2: begin
        sp  = ~rise & tick & (tcnt == TW'(DCLICK_TICKS - 1));
        nxt = rise ? PRESSED2 : sp ? IDLE : WAIT2;
      end
      PRESSED2: begin
        dc  = fall;
        nxt = fall ? IDLE : PRESSED2;
      end
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pcnt         <= '0;
      tcnt         <= '0;
      db_d         <= 1'b0;
      state        <= IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      event_cnt    <= '0;
      busy         <= 1'b0;
    end else begin
      pcnt         <= tick ? '0 : pcnt + 1'b1;
      db_d         <= db_in;
      state        <= nxt;
      tcnt         <= (nxt != state) ? '0 : tcnt + TW'(tick);
      short_press  <= sp;
      long_press   <= lp;
      double_click <= dc;
      event_cnt    <= clr ? '0 : event_cnt + CNT_W'(sp | lp | dc);
      busy         <= nxt != IDLE;
    end
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed gesture scenarios with hand-derived pulse timing windows
module tb_btn_event_decoder;
  localparam int TD = 4, LT = 5, DT = 3, CW = 3;
  logic          clk = 1'b0, rst = 1'b1, db_in = 1'b0, clr = 1'b0;
  logic          short_press, long_press, double_click, busy;
  logic [CW-1:0] event_cnt;
  int n_cmp = 0, n_bad = 0, pe = 0, pr = 0, edge_at = 0;
  int n_sp = 0, n_lp = 0, n_dc = 0, sp_edge = 0, lp_edge = 0;

  btn_event_decoder #(.TICK_DIV(TD), .LONG_TICKS(LT), .DCLICK_TICKS(DT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .db_in(db_in), .clr(clr), .short_press(short_press),
    .long_press(long_press), .double_click(double_click), .event_cnt(event_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pe++;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulses are tallied at the falling edge, tagged with the clk edge that registered them
  always @(negedge clk)
    if (!rst) begin
      if (short_press) begin n_sp++; sp_edge = pe; end
      if (long_press) begin n_lp++; lp_edge = pe; end
      if (double_click) n_dc++;
      if (int'(short_press) + int'(long_press) + int'(double_click) > 1)
        chk("one_pulse", int'(short_press) + int'(long_press) + int'(double_click), 1);
    end

  task automatic tock;
    @(negedge clk);
    #1;
  endtask

  // Drive db_in=v so it is sampled at exactly n rising edges; edge_at is the first of them
  task automatic hold(input logic v, input int n);
    tock;
    db_in   = v;
    edge_at = pe + 1;
    repeat (n - 1) tock;
  endtask

  initial begin
    int b_sp, b_lp, b_dc, re, fe, len, t1;
    repeat (3) tock;
    chk("rst_outs", {short_press, long_press, double_click, busy, event_cnt}, 0);
    tock;
    rst = 1'b0;
    pr  = pe;
    // short press
    b_sp = n_sp; b_lp = n_lp;
    hold(1, 8);
    hold(0, 20);
    fe = edge_at;
    chk("s1_sp_count", n_sp - b_sp, 1);
    chk("s1_lp_count", n_lp - b_lp, 0);
    chk("s1_sp_lat_9_12", int'(sp_edge - fe >= 9 && sp_edge - fe <= 12), 1);
    chk("s1_cnt", event_cnt, 1);
    chk("s1_busy", busy, 0);
    // long press
    b_sp = n_sp; b_lp = n_lp; b_dc = n_dc;
    hold(1, 30);
    re = edge_at;
    chk("s2_lp_count", n_lp - b_lp, 1);
    chk("s2_lp_lat_17_20", int'(lp_edge - re >= 17 && lp_edge - re <= 20), 1);
    chk("s2_busy_held", busy, 1);
    hold(0, 1);
    tock;
    chk("s2_busy_drop", busy, 0);
    hold(0, 20);
    chk("s2_no_more", (n_lp - b_lp) * 100 + (n_sp - b_sp) * 10 + (n_dc - b_dc), 100);
    chk("s2_cnt", event_cnt, 2);
    // double click
    b_sp = n_sp; b_dc = n_dc;
    hold(1, 6);
    hold(0, 4);
    hold(1, 6);
    hold(0, 1);
    tock;
    chk("s3_dc_pulse", double_click, 1);
    hold(0, 20);
    chk("s3_dc_count", n_dc - b_dc, 1);
    chk("s3_sp_count", n_sp - b_sp, 0);
    chk("s3_cnt", event_cnt, 3);
    // fall exactly on the long threshold tick, then rise exactly on the WAIT2 timeout tick
    b_sp = n_sp; b_lp = n_lp; b_dc = n_dc;
    tock;
    db_in = 1'b1;
    re    = pe + 1;
    t1    = re + 1;
    while ((t1 - pr) % TD != 0) t1++;
    len = t1 + (LT - 1) * TD - re;
    repeat (len - 1) tock;
    hold(0, DT * TD);
    chk("s4_wait2_busy", busy, 1);
    chk("s4_no_lp", n_lp - b_lp, 0);
    hold(1, 6);
    chk("s4_no_sp", n_sp - b_sp, 0);
    chk("s4_pressed2_busy", busy, 1);
    hold(0, 1);
    tock;
    chk("s4_dc_pulse", double_click, 1);
    hold(0, 5);
    chk("s4_cnt", event_cnt, 4);
    // wrap and clear
    tock;
    clr = 1'b1;
    tock;
    clr = 1'b0;
    chk("s5_clr", event_cnt, 0);
    b_sp = n_sp;
    repeat (9) begin
      hold(1, 3);
      hold(0, 15);
    end
    chk("s5_sp_count", n_sp - b_sp, 9);
    chk("s5_wrap", event_cnt, 1);
    hold(1, 3);
    hold(0, 3);
    hold(1, 3);
    hold(0, 1);
    clr = 1'b1;
    tock;
    clr = 1'b0;
    chk("s5_clr_pulse", double_click, 1);
    chk("s5_clr_beats_evt", event_cnt, 0);
    hold(0, 5);
    // reset mid-press with db_in still high afterwards
    hold(1, 5);
    tock;
    rst = 1'b1;
    #1;
    chk("s6_rst_outs", {short_press, long_press, double_click, busy, event_cnt}, 0);
    b_lp = n_lp;
    tock;
    tock;
    rst = 1'b0;
    pr  = pe;
    re  = pe + 1;
    tock;
    chk("s6_repress_busy", busy, 1);
    hold(1, 25);
    chk("s6_lp_count", n_lp - b_lp, 1);
    chk("s6_lp_lat_17_20", int'(lp_edge - re >= 17 && lp_edge - re <= 20), 1);
    chk("s6_cnt", event_cnt, 1);
    hold(0, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
